// File: rtl/counter_4bit_if.sv
// Count output bundle shared by the counter (master) and its consumers (slave).
// Q is the registered count value.
interface counter_4bit_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Q;

  modport master (output Q);
  modport slave  (input  Q);
endinterface

// File: rtl/counter_4bit.sv
// Free-running up-counter with a programmable terminal count and reset value.
// The count is published on the interface straight from the flop.
module counter_4bit #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int RESET_VAL = 0
) (
  input  logic           clk,
  input  logic           reset,
  counter_4bit_if.master cnt_if
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  // Reject parameter sets that cannot be represented in WIDTH bits.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "counter_4bit: WIDTH must be >= 1");
    end
    if (MAX_COUNT < 0 || MAX_COUNT >= 2**WIDTH) begin : g_bad_max
      $fatal(1, "counter_4bit: MAX_COUNT must be < 2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= 2**WIDTH) begin : g_bad_rst
      $fatal(1, "counter_4bit: RESET_VAL must be < 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count; values above MAX_COUNT climb modulo 2**WIDTH until they hit it.
  always_comb begin
    count_d = count_q;
    if (count_q == MAX_V) begin
      count_d = '0;
    end else begin
      count_d = count_q + ONE_V;
    end
  end

  // Count register; reset wins over any coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign cnt_if.Q = count_q;

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit: default, decade and reset-value-5 instances
// driven from one clock and one reset.
module tb_counter_4bit;

  logic clk;
  logic clk_en;
  logic reset;
  int   total;
  int   bad;

  counter_4bit_if #(.WIDTH(4)) if_def ();
  counter_4bit_if #(.WIDTH(4)) if_dec ();
  counter_4bit_if #(.WIDTH(4)) if_rv5 ();

  counter_4bit #(.WIDTH(4)) dut_def (
    .clk    (clk),
    .reset  (reset),
    .cnt_if (if_def)
  );

  counter_4bit #(.WIDTH(4), .MAX_COUNT(9)) dut_dec (
    .clk    (clk),
    .reset  (reset),
    .cnt_if (if_dec)
  );

  counter_4bit #(.WIDTH(4), .RESET_VAL(5)) dut_rv5 (
    .clk    (clk),
    .reset  (reset),
    .cnt_if (if_rv5)
  );

  // Gated 10-unit clock so the async reset can be checked with clk stopped.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_def,
                           input logic [3:0] e_dec, input logic [3:0] e_rv5);
    check({tag, "_def"}, if_def.Q, e_def);
    check({tag, "_dec"}, if_dec.Q, e_dec);
    check({tag, "_rv5"}, if_rv5.Q, e_rv5);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    clk_en = 1'b0;
    reset  = 1'b1;

    // Async reset with clock stopped.
    #3;
    reset = 1'b0;
    #1;
    check_all("async_rst", 4'd0, 4'd0, 4'd5);

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold", 4'd0, 4'd0, 4'd5);

    // Release and count through the wrap points.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("count%0d", i), 4'(i % 16), 4'(i % 10), 4'((5 + i) % 16));
    end

    // Mid-period reset while the default counter holds 7.
    #2;
    reset = 1'b0;
    #1;
    check_all("mid_rst", 4'd0, 4'd0, 4'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("mid_hold%0d", i), 4'd0, 4'd0, 4'd5);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("rel1", 4'd1, 4'd1, 4'd6);
    @(posedge clk);
    #1;
    check_all("rel2", 4'd2, 4'd2, 4'd7);

    // Reset asserted coincident with a rising edge.
    @(posedge clk);
    reset = 1'b0;
    #1;
    check_all("edge_rst", 4'd0, 4'd0, 4'd5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("edge_rel", 4'd1, 4'd1, 4'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
